// File: rtl/axi4_sram_slice.sv
// axi4_sram_slice: per-channel AXI4 register slice in front of the SRAM FSM slave.
// Each enabled channel gets a 2-entry skid buffer. The buffer registers both VALID
// and READY and sustains one beat per cycle. A disabled channel is a plain wire.

`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

// Generic 2-entry skid buffer: main reg drives dst, skid reg absorbs the beat that
// arrives in the cycle dst stalls. READY toward src is a flop, never a comb path.
module axi4_sram_skid #(
  parameter int W  = 8,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         dst_valid,
  input  logic         dst_ready,
  output logic [W-1:0] dst_data
);
  if (EN) begin : g_reg
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         rdy_q, rdy_d;
    logic         vld_q, vld_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_hs, out_hs;

    assign in_hs     = src_valid & rdy_q;
    assign out_hs    = vld_q & dst_ready;
    assign src_ready = rdy_q;
    assign dst_valid = vld_q;
    assign dst_data  = main_q;

    // Occupancy transitions; payload regs only move on an accepted or drained beat.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        ST_EMPTY: begin
          if (in_hs) begin
            state_d = ST_ONE;
            main_d  = src_data;
          end
        end
        ST_ONE: begin
          if (in_hs && !out_hs) begin
            state_d = ST_FULL;
            skid_d  = src_data;
          end else if (in_hs && out_hs) begin
            main_d  = src_data;
          end else if (out_hs) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // src_ready is low here, so only a drain can happen.
          if (out_hs) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Handshake flags are decoded from the next state so both sides see pure flops.
    always_comb begin
      rdy_d = (state_d != ST_FULL);
      vld_d = (state_d != ST_EMPTY);
    end

    // State, handshake and payload registers; reset empties the slice and drops beats.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_EMPTY;
        rdy_q   <= 1'b1;
        vld_q   <= 1'b0;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        rdy_q   <= rdy_d;
        vld_q   <= vld_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end else begin : g_byp
    logic unused_clk_rst;
    assign unused_clk_rst = clk & rst_n;
    assign dst_valid      = src_valid;
    assign dst_data       = src_data;
    assign src_ready      = dst_ready;
  end
endmodule

module axi4_sram_slice #(
  parameter bit AW_SLICE_EN = 1'b1,
  parameter bit W_SLICE_EN  = 1'b1,
  parameter bit AR_SLICE_EN = 1'b1,
  parameter bit R_SLICE_EN  = 1'b1,
  parameter bit B_SLICE_EN  = 1'b1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  output logic                          s_axi_aclk,
  output logic                          s_axi_aresetn,
  output logic                          m_axi_aclk,
  output logic                          m_axi_aresetn,
  // upstream AW
  input  logic [`AXI4_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [`AXI4_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic [`AXI4_USER_WIDTH-1:0]   s_axi_awuser,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  // upstream W
  input  logic [`AXI4_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [`AXI4_WSTRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic [`AXI4_USER_WIDTH-1:0]   s_axi_wuser,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  // upstream B
  output logic [`AXI4_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic [`AXI4_USER_WIDTH-1:0]   s_axi_buser,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  // upstream AR
  input  logic [`AXI4_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [`AXI4_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic [`AXI4_USER_WIDTH-1:0]   s_axi_aruser,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  // upstream R
  output logic [`AXI4_ID_WIDTH-1:0]     s_axi_rid,
  output logic [`AXI4_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic [`AXI4_USER_WIDTH-1:0]   s_axi_ruser,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  // downstream AW
  output logic [`AXI4_ID_WIDTH-1:0]     m_axi_awid,
  output logic [`AXI4_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [`AXI4_USER_WIDTH-1:0]   m_axi_awuser,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  // downstream W
  output logic [`AXI4_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [`AXI4_WSTRB_WIDTH-1:0]  m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic [`AXI4_USER_WIDTH-1:0]   m_axi_wuser,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  // downstream B
  input  logic [`AXI4_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic [`AXI4_USER_WIDTH-1:0]   m_axi_buser,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // downstream AR
  output logic [`AXI4_ID_WIDTH-1:0]     m_axi_arid,
  output logic [`AXI4_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic [`AXI4_USER_WIDTH-1:0]   m_axi_aruser,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  // downstream R
  input  logic [`AXI4_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [`AXI4_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic [`AXI4_USER_WIDTH-1:0]   m_axi_ruser,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);
  localparam int IDW = `AXI4_ID_WIDTH;
  localparam int AW  = `AXI4_ADDR_WIDTH;
  localparam int DW  = `AXI4_DATA_WIDTH;
  localparam int SW  = `AXI4_WSTRB_WIDTH;
  localparam int UW  = `AXI4_USER_WIDTH;

  // All payload fields of a channel travel as one vector through the same buffer.
  localparam int AX_W = IDW + AW + 8 + 3 + 2 + UW;
  localparam int WD_W = DW + SW + 1 + UW;
  localparam int RD_W = IDW + DW + 2 + 1 + UW;
  localparam int BR_W = IDW + 2 + UW;

  logic [AX_W-1:0] aw_dst, ar_dst;
  logic [WD_W-1:0] w_dst;
  logic [RD_W-1:0] r_dst;
  logic [BR_W-1:0] b_dst;

  assign s_axi_aclk    = aclk;
  assign m_axi_aclk    = aclk;
  assign s_axi_aresetn = aresetn;
  assign m_axi_aresetn = aresetn;

  axi4_sram_skid #(.W(AX_W), .EN(AW_SLICE_EN)) u_aw (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_axi_awvalid), .src_ready(s_axi_awready),
    .src_data({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awuser}),
    .dst_valid(m_axi_awvalid), .dst_ready(m_axi_awready), .dst_data(aw_dst));
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awuser} = aw_dst;

  axi4_sram_skid #(.W(WD_W), .EN(W_SLICE_EN)) u_w (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_axi_wvalid), .src_ready(s_axi_wready),
    .src_data({s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser}),
    .dst_valid(m_axi_wvalid), .dst_ready(m_axi_wready), .dst_data(w_dst));
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = w_dst;

  axi4_sram_skid #(.W(AX_W), .EN(AR_SLICE_EN)) u_ar (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(s_axi_arvalid), .src_ready(s_axi_arready),
    .src_data({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_aruser}),
    .dst_valid(m_axi_arvalid), .dst_ready(m_axi_arready), .dst_data(ar_dst));
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_aruser} = ar_dst;

  // Response channels run backward: the SRAM slave is the sender.
  axi4_sram_skid #(.W(RD_W), .EN(R_SLICE_EN)) u_r (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(m_axi_rvalid), .src_ready(m_axi_rready),
    .src_data({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser}),
    .dst_valid(s_axi_rvalid), .dst_ready(s_axi_rready), .dst_data(r_dst));
  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser} = r_dst;

  axi4_sram_skid #(.W(BR_W), .EN(B_SLICE_EN)) u_b (
    .clk(aclk), .rst_n(aresetn),
    .src_valid(m_axi_bvalid), .src_ready(m_axi_bready),
    .src_data({m_axi_bid, m_axi_bresp, m_axi_buser}),
    .dst_valid(s_axi_bvalid), .dst_ready(s_axi_bready), .dst_data(b_dst));
  assign {s_axi_bid, s_axi_bresp, s_axi_buser} = b_dst;
endmodule
